// File: rtl/chip_seq_pkg.sv
// Shared types and constants for the chip test sequencer: FSM state encoding,
// select width, default parameter values and the slot one-hot helper.
package chip_seq_pkg;

  localparam int SEL_W              = 4;
  localparam int DEF_NUM_CHIPS      = 8;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_SHOW    = 3'd4,
    ST_RELEASE = 3'd5,
    ST_TIMEOUT = 3'd6
  } seq_state_e;

  // One-hot of a slot index at the widest legal slot count; callers truncate.
  function automatic logic [15:0] sel_onehot(input logic [SEL_W-1:0] sel);
    return 16'h0001 << sel;
  endfunction

endpackage

// File: rtl/chip_test_sequencer_if.sv
// Bundle between the sequencer, the operator buttons and the chip tester slots.
// master: the user/tester side; slave: the sequencer.
interface chip_test_sequencer_if import chip_seq_pkg::*; #(
  parameter int NUM_CHIPS = DEF_NUM_CHIPS
);

  logic                 Start;
  logic                 Ack;
  logic [SEL_W-1:0]     Sel;
  logic [NUM_CHIPS-1:0] Done_vec;
  logic [NUM_CHIPS-1:0] RSLT_vec;
  logic [NUM_CHIPS-1:0] Run_vec;
  logic [NUM_CHIPS-1:0] DISP_RSLT_vec;
  logic                 Busy;
  logic                 Pass;
  logic                 Fail;
  logic                 Timeout;
  logic                 SelErr;
  logic [SEL_W-1:0]     Active_sel;

  modport master (
    output Start, Ack, Sel, Done_vec, RSLT_vec,
    input  Run_vec, DISP_RSLT_vec, Busy, Pass, Fail, Timeout, SelErr, Active_sel
  );

  modport slave (
    input  Start, Ack, Sel, Done_vec, RSLT_vec,
    output Run_vec, DISP_RSLT_vec, Busy, Pass, Fail, Timeout, SelErr, Active_sel
  );

endinterface

// File: rtl/chip_seq_edge.sv
// Rising-edge detector for a level button: the history bit is registered with
// synchronous reset, so a level already high when reset lifts counts as an edge.
module chip_seq_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;

  // Remember last cycle's level of the button.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/chip_test_sequencer.sv
// Operator-driven sequencer that launches one chip tester, waits for its result
// and shows it on lamps. Define CHIP_SEQ_TIMEOUT_EN to bound the WAIT state.
module chip_test_sequencer import chip_seq_pkg::*; #(
  parameter int NUM_CHIPS      = DEF_NUM_CHIPS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic                  Clk,
  input logic                  Reset,
  chip_test_sequencer_if.slave bus
);

  if (NUM_CHIPS < 2 || NUM_CHIPS > 16 ||
      TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("chip_test_sequencer: NUM_CHIPS or TIMEOUT_CYCLES out of range");
  end

  localparam logic [SEL_W:0] NUM_CHIPS_W = (SEL_W+1)'(NUM_CHIPS);

  seq_state_e           state_q, state_d;
  logic [SEL_W-1:0]     act_q, act_d;
  logic [NUM_CHIPS-1:0] run_q, run_d;
  logic [NUM_CHIPS-1:0] disp_q, disp_d;
  logic                 busy_q, busy_d;
  logic                 pass_q, pass_d;
  logic                 fail_q, fail_d;
  logic                 tmo_q, tmo_d;
  logic                 selerr_q, selerr_d;

  logic                 start_rise_s;
  logic                 ack_rise_s;
  logic                 sel_ok_s;
  logic                 done_sel_s;
  logic                 rslt_sel_s;
  logic [NUM_CHIPS-1:0] act_onehot_s;
  logic [NUM_CHIPS-1:0] act_onehot_d_s;

`ifdef CHIP_SEQ_TIMEOUT_EN
  localparam int             CNT_W    = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  chip_seq_edge u_start_edge (
    .clk_i  (Clk),
    .rst_i  (Reset),
    .sig_i  (bus.Start),
    .rise_o (start_rise_s)
  );

  chip_seq_edge u_ack_edge (
    .clk_i  (Clk),
    .rst_i  (Reset),
    .sig_i  (bus.Ack),
    .rise_o (ack_rise_s)
  );

  // Masking with the latched slot makes every other slot's Done/RSLT invisible.
  assign sel_ok_s       = ({1'b0, bus.Sel} < NUM_CHIPS_W);
  assign act_onehot_s   = NUM_CHIPS'(sel_onehot(act_q));
  assign act_onehot_d_s = NUM_CHIPS'(sel_onehot(act_d));
  assign done_sel_s     = |(bus.Done_vec & act_onehot_s);
  assign rslt_sel_s     = |(bus.RSLT_vec & act_onehot_s);

  // Next-state, latched select, lamps and the WAIT counter.
  always_comb begin
    state_d  = state_q;
    act_d    = act_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    tmo_d    = tmo_q;
    selerr_d = 1'b0;
`ifdef CHIP_SEQ_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_rise_s && sel_ok_s) begin
          act_d   = bus.Sel;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          tmo_d   = 1'b0;
          state_d = ST_LAUNCH;
        end else if (start_rise_s) begin
          selerr_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
`ifdef CHIP_SEQ_TIMEOUT_EN
        cnt_d   = {CNT_W{1'b0}};
`endif
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Done seen in the last counted cycle still wins over the timeout.
        if (done_sel_s) begin
          state_d = ST_CAPTURE;
`ifdef CHIP_SEQ_TIMEOUT_EN
        end else if (cnt_q == CNT_LAST) begin
          tmo_d   = 1'b1;
          state_d = ST_TIMEOUT;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
`else
        end else begin
          state_d = ST_WAIT;
        end
`endif
      end
      ST_CAPTURE: begin
        pass_d  = rslt_sel_s;
        fail_d  = ~rslt_sel_s;
        state_d = ST_SHOW;
      end
      ST_SHOW: begin
        if (ack_rise_s) begin
          state_d = ST_RELEASE;
        end else begin
          state_d = ST_SHOW;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
`ifdef CHIP_SEQ_TIMEOUT_EN
      ST_TIMEOUT: begin
        if (ack_rise_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_TIMEOUT;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Strobes and Busy are derived from the upcoming state so they register in step with it.
  always_comb begin
    run_d  = {NUM_CHIPS{1'b0}};
    disp_d = {NUM_CHIPS{1'b0}};
    if (state_d == ST_LAUNCH) begin
      run_d = act_onehot_d_s;
    end else begin
      run_d = {NUM_CHIPS{1'b0}};
    end
    if (state_d == ST_RELEASE) begin
      disp_d = act_onehot_d_s;
`ifdef CHIP_SEQ_TIMEOUT_EN
    end else if (state_d == ST_TIMEOUT && state_q != ST_TIMEOUT) begin
      disp_d = act_onehot_d_s;
`endif
    end else begin
      disp_d = {NUM_CHIPS{1'b0}};
    end
    busy_d = (state_d != ST_IDLE) && (state_d != ST_SHOW);
  end

  // State and output registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      act_q    <= {SEL_W{1'b0}};
      run_q    <= {NUM_CHIPS{1'b0}};
      disp_q   <= {NUM_CHIPS{1'b0}};
      busy_q   <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      tmo_q    <= 1'b0;
      selerr_q <= 1'b0;
`ifdef CHIP_SEQ_TIMEOUT_EN
      cnt_q    <= {CNT_W{1'b0}};
`endif
    end else begin
      state_q  <= state_d;
      act_q    <= act_d;
      run_q    <= run_d;
      disp_q   <= disp_d;
      busy_q   <= busy_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      tmo_q    <= tmo_d;
      selerr_q <= selerr_d;
`ifdef CHIP_SEQ_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign bus.Run_vec       = run_q;
  assign bus.DISP_RSLT_vec = disp_q;
  assign bus.Busy          = busy_q;
  assign bus.Pass          = pass_q;
  assign bus.Fail          = fail_q;
  assign bus.Timeout       = tmo_q;
  assign bus.SelErr        = selerr_q;
  assign bus.Active_sel    = act_q;

endmodule

// File: tb/tb_chip_test_sequencer.sv
// Randomized transaction bench for chip_test_sequencer; expectations come from a
// transaction-level model of lamps/selection and the per-phase strobe rules.
module tb_chip_test_sequencer;
  import chip_seq_pkg::*;

  localparam int NC = 8;
  localparam int TC = 16;
`ifdef CHIP_SEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset;
  int   checks   = 0;
  int   failures = 0;

  // Model of the persistent outputs.
  logic exp_pass, exp_fail, exp_tmo;
  int   exp_act;

  chip_test_sequencer_if #(.NUM_CHIPS(NC)) bus ();

  chip_test_sequencer #(.NUM_CHIPS(NC), .TIMEOUT_CYCLES(TC)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [31:0] slot_bit(input int s);
    return 32'd1 << s;
  endfunction

  task automatic check_outs(input string tag, input logic [31:0] run_e, input logic [31:0] disp_e,
                            input logic busy_e, input logic selerr_e);
    check_val({tag, ".run"},    32'(bus.Run_vec),       run_e);
    check_val({tag, ".disp"},   32'(bus.DISP_RSLT_vec), disp_e);
    check_val({tag, ".busy"},   32'(bus.Busy),          32'(busy_e));
    check_val({tag, ".selerr"}, 32'(bus.SelErr),        32'(selerr_e));
    check_val({tag, ".pass"},   32'(bus.Pass),          32'(exp_pass));
    check_val({tag, ".fail"},   32'(bus.Fail),          32'(exp_fail));
    check_val({tag, ".tmo"},    32'(bus.Timeout),       32'(exp_tmo));
    check_val({tag, ".act"},    32'(bus.Active_sel),    32'(exp_act));
  endtask

  // Random activity on every slot, with the selected slot forced to given values.
  task automatic drive_slots(input int s, input logic done_b, input logic rslt_b);
    bus.Done_vec = NC'($urandom);
    bus.RSLT_vec = NC'($urandom);
    if (s < NC) begin
      bus.Done_vec[s] = done_b;
      bus.RSLT_vec[s] = rslt_b;
    end
  endtask

  task automatic apply_reset(input string tag);
    Reset     = 1'b1;
    bus.Start = 1'b0;
    bus.Ack   = 1'b0;
    tick();
    exp_pass = 1'b0;
    exp_fail = 1'b0;
    exp_tmo  = 1'b0;
    exp_act  = 0;
    check_outs(tag, 32'd0, 32'd0, 1'b0, 1'b0);
    Reset = 1'b0;
  endtask

  // One operator transaction. k = WAIT cycles with Done low before Done rises.
  // abort_at: 0 none, 1 reset in LAUNCH, 2 reset in WAIT, 3 reset in RELEASE.
  task automatic run_txn(input int s, input int k, input logic r, input bit start_noise,
                         input bit ack_with_start, input int dwell, input int abort_at);
    bit timed_out;
    int n;
    bus.Sel   = 4'(s);
    bus.Start = 1'b1;
    bus.Ack   = ack_with_start;
    drive_slots(s, 1'b0, 1'b0);
    tick();
    if (s >= NC) begin
      check_outs("selerr", 32'd0, 32'd0, 1'b0, 1'b1);
      bus.Start = 1'b0;
      bus.Ack   = 1'b0;
      tick();
      check_outs("selerr_end", 32'd0, 32'd0, 1'b0, 1'b0);
      return;
    end
    exp_act  = s;
    exp_pass = 1'b0;
    exp_fail = 1'b0;
    exp_tmo  = 1'b0;
    check_outs("launch", slot_bit(s), 32'd0, 1'b1, 1'b0);
    if (abort_at == 1) begin
      apply_reset("rst_launch");
      return;
    end
    bus.Start = 1'b0;
    bus.Ack   = 1'b0;
    tick();
    check_outs("wait_entry", 32'd0, 32'd0, 1'b1, 1'b0);
    timed_out = TMO_EN && (k >= TC);
    n = timed_out ? TC : k;
    for (int i = 0; i < n; i++) begin
      drive_slots(s, 1'b0, 1'($urandom));
      bus.Sel = 4'($urandom);
      bus.Ack = 1'($urandom);
      if (start_noise) bus.Start = 1'($urandom);
      tick();
      if (timed_out && i == n - 1) begin
        exp_tmo = 1'b1;
        check_outs("tmo_entry", 32'd0, slot_bit(s), 1'b1, 1'b0);
      end else begin
        check_outs("wait", 32'd0, 32'd0, 1'b1, 1'b0);
      end
      if (abort_at == 2 && i == n / 2) begin
        apply_reset("rst_wait");
        return;
      end
    end
    bus.Start = 1'b0;
    bus.Ack   = 1'b0;
    bus.Sel   = 4'(s);
    if (timed_out) begin
      drive_slots(s, 1'($urandom), 1'($urandom));
      tick();
      check_outs("tmo_hold", 32'd0, 32'd0, 1'b1, 1'b0);
      bus.Ack = 1'b1;
      tick();
      check_outs("tmo_ack", 32'd0, 32'd0, 1'b0, 1'b0);
      bus.Ack = 1'b0;
      tick();
      check_outs("tmo_idle", 32'd0, 32'd0, 1'b0, 1'b0);
      return;
    end
    drive_slots(s, 1'b1, r);
    tick();
    check_outs("capture", 32'd0, 32'd0, 1'b1, 1'b0);
    drive_slots(s, 1'b0, r);
    tick();
    exp_pass = r;
    exp_fail = ~r;
    check_outs("show", 32'd0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < dwell; i++) begin
      drive_slots(s, 1'($urandom), 1'($urandom));
      bus.Start = 1'($urandom);
      tick();
      check_outs("show_hold", 32'd0, 32'd0, 1'b0, 1'b0);
    end
    bus.Start = 1'b0;
    bus.Ack   = 1'b1;
    tick();
    check_outs("release", 32'd0, slot_bit(s), 1'b1, 1'b0);
    if (abort_at == 3) begin
      apply_reset("rst_release");
      return;
    end
    bus.Ack = 1'b0;
    tick();
    check_outs("idle", 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    Reset        = 1'b1;
    bus.Start    = 1'b0;
    bus.Ack      = 1'b0;
    bus.Sel      = 4'd0;
    bus.Done_vec = {NC{1'b0}};
    bus.RSLT_vec = {NC{1'b0}};
    exp_pass = 1'b0;
    exp_fail = 1'b0;
    exp_tmo  = 1'b0;
    exp_act  = 0;
    tick();
    tick();
    check_outs("reset", 32'd0, 32'd0, 1'b0, 1'b0);
    Reset = 1'b0;
    tick();
    check_outs("post_reset", 32'd0, 32'd0, 1'b0, 1'b0);

    run_txn(3, 4, 1'b1, 1'b0, 1'b0, 2, 0);          // pass on slot 3
    run_txn(0, 3, 1'b0, 1'b0, 1'b0, 1, 0);          // fail on slot 0, noisy neighbours
    run_txn(9, 0, 1'b0, 1'b0, 1'b0, 0, 0);          // rejected select
    run_txn(15, 0, 1'b0, 1'b0, 1'b1, 0, 0);         // rejected select with Ack
    run_txn(5, 6, 1'b1, 1'b1, 1'b0, 0, 0);          // Start edges during WAIT
    run_txn(2, TC - 1, 1'b1, 1'b0, 1'b0, 0, 0);     // Done in the final counted cycle
    run_txn(2, TC, 1'b0, 1'b0, 1'b0, 0, 0);         // timeout boundary
    run_txn(6, 100, 1'b1, 1'b0, 1'b0, 0, 0);        // long WAIT
    run_txn(4, 0, 1'b1, 1'b0, 1'b1, 0, 0);          // Start and Ack together in IDLE
    run_txn(7, 8, 1'b1, 1'b0, 1'b0, 0, 2);          // reset in WAIT
    run_txn(1, 2, 1'b1, 1'b0, 1'b0, 0, 0);
    run_txn(3, 2, 1'b0, 1'b0, 1'b0, 1, 3);          // reset in RELEASE
    run_txn(3, 1, 1'b1, 1'b0, 1'b0, 0, 1);          // reset in LAUNCH
    run_txn(3, 5, 1'b1, 1'b0, 1'b0, 0, 0);

    for (int t = 0; t < 40; t++) begin
      run_txn($urandom_range(0, 11), $urandom_range(0, 20), 1'($urandom),
              1'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 3), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
